// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler driving the select lines of the shared 8:1 mux.
// Grants one requester per bounded burst; valid marks cycles where Y is granted data.
//
//   state | meaning
//   IDLE  | no burst, waiting for en and a request
//   GRANT | burst in progress, sel fixed, valid high
//   GAP   | one-cycle gap after a burst, done high, re-arbitrates
module mux8_rr_scheduler #(
  parameter int BURST_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic       S2,
  output logic       S1,
  output logic       S0,
  output logic       valid,
  output logic       done
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_gnt, w_gnt_nxt;
  logic [2:0]       r_sel, w_sel_nxt;
  logic [2:0]       r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_done, w_done_nxt;
  logic             w_found;
  logic [2:0]       w_win;

  // Descending scan so the smallest offset from ptr is the last one written.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    for (int i = 7; i >= 0; i--) begin
      if (req[r_ptr + 3'(i)]) begin
        w_found = 1'b1;
        w_win   = r_ptr + 3'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = r_valid;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE, GAP: begin
        if (en && w_found) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = 8'h01 << w_win;
          w_sel_nxt   = w_win;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = 8'h00;
          w_valid_nxt = 1'b0;
        end
      end
      GRANT: begin
        // Only the granted line is watched; sel stays on the last index through GAP.
        if (!req[r_sel] || (r_cnt == CNT_LAST)) begin
          w_state_nxt = GAP;
          w_gnt_nxt   = 8'h00;
          w_valid_nxt = 1'b0;
          w_done_nxt  = 1'b1;
          w_ptr_nxt   = r_sel + 3'd1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = 8'h00;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= 8'h00;
      r_sel   <= 3'd0;
      r_ptr   <= 3'd0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign gnt        = r_gnt;
  assign {S2,S1,S0} = r_sel;
  assign valid      = r_valid;
  assign done       = r_done;

endmodule

// File: doc/mux8_rr_scheduler.md
# mux8_rr_scheduler

Round-robin scheduler that shares the team's 8:1 gate-level mux between eight requesters. It arbitrates among request lines and grants one requester at a time for a bounded burst. For each burst it drives the mux select lines S2..S0 and a one-hot grant, and it marks with a valid strobe the cycles in which the mux output Y carries the granted requester's data. The block sits directly in front of the mux select inputs; the datapath itself stays combinational.

## Interface
- BURST_LEN, 8, maximum grant cycles per burst; legal range 1..256
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset (sampled on rising clk)
- en  input  1  arbitration enable; low blocks new grants only
- req  input  8  request lines, bit i = requester i (mux input Ii)
- gnt  output  8  one-hot grant, registered
- S2, S1, S0  output  1 each  mux select, binary index of granted requester
- valid  output  1  high while a burst is in progress (Y is granted data)
- done  output  1  one-cycle pulse in the gap cycle after each burst

## Operation
- States: IDLE, GRANT, GAP. Internal: ptr[2:0] (next search start), cnt (width clog2(BURST_LEN), minimum 1 bit).
- Arbitration, in IDLE or GAP with en=1 and req!=0:
  - Winner is the first set bit searching ptr, ptr+1, ..., ptr+7 mod 8.
  - Next state is GRANT, with gnt=onehot(winner), {S2,S1,S0}=winner, valid=1, cnt=0.
- IDLE with en=0 or req=0: stay IDLE, with gnt=0 and valid=0.
- GRANT behaviour on each edge:
  - If req[sel]=0 (early release) or cnt=BURST_LEN-1, go to GAP.
  - Otherwise, cnt increments.
- GRANT→GAP transition:
  - gnt=0, valid=0, done=1 during GAP.
  - ptr=sel+1 mod 8, so 7 wraps to 0.
  - S2..S0 hold the last index.
- GAP: arbitrate as above. If no winner or en=0, go to IDLE.
- en only gates new grants. Dropping en mid-burst does not shorten the burst.
- Requests arriving or changing during GRANT do not change sel. Only req[sel] is observed during GRANT.
- BURST_LEN=1 gives exactly one valid cycle per grant.
- Reset values: state=IDLE, gnt=8'h00, S2..S0=0, valid=0, done=0, ptr=0, cnt=0.
- Reset mid-burst: the burst is aborted at that edge, done is not pulsed, and ptr returns to 0.

## Timing
- Grant latency from IDLE: req sampled high at edge k gives gnt/valid high after edge k.
- Burst length: valid stays high for min(BURST_LEN, N) cycles, where req[sel] is first sampled low on the N-th GRANT cycle.
- Back-to-back: exactly one GAP cycle (valid=0) between consecutive bursts.
- Full rotation under saturation: 8*(BURST_LEN+1) cycles.
- All outputs are registered; there is no combinational path from req or en to any output.
- gnt, valid and S2..S0 change only on clk edges.
- Consumer rules:
  - Sample Y on edges where valid=1.
  - Y is stable one mux delay after the S2..S0 update.

## Test plan
- Reset: rst_n=0 for 2 cycles with req=8'hFF, en=1 → gnt=8'h00, valid=0, S=0, done=0. Release → gnt=8'h01 after the next edge.
- Single requester: BURST_LEN=4, req=8'h10 held → gnt=8'h10 and S=3'd4 with valid for 4 cycles. Then 1 GAP cycle with done=1, then regrant of 8'h10.
- Saturation and wrap: req=8'hFF → grant order 0,1,...,7,0. Each burst is 4 valid cycles plus 1 gap cycle; second grant to 0 starts 40 cycles after the first.
- Early release: req=8'h04, req[2] dropped on the 2nd GRANT cycle → valid high 2 cycles, done pulses, ptr=3. Next req=8'h05 → grant to 0 after wrap search 3..7,0.
- Enable: en dropped on the 1st cycle of a burst → burst runs the full 4 cycles, then IDLE with gnt=0 while req=8'hFF. en raised → grant on the next edge to ptr's winner.
- Reset mid-burst: rst_n=0 on the 2nd GRANT cycle of requester 5 → next edge gives all outputs at reset values with no done pulse. After release with req=8'hFF → grant to 0.
